// File: rtl/dct_daa_writer.sv
// dct_daa_writer
//
// Takes per-device ENTDAA results and packs each one into a 128-bit Device
// Characteristic Table entry. Each device supplies six PID bytes (MSB first),
// then BCR, then DCR, plus a dynamic address. The entry is written through the
// DCT hardware port. Consecutive devices go to consecutive indices, and the
// index wraps at DctDepth.
//
// Optional feature: define DCT_DAA_READBACK_EN to read every entry back after
// it is written. A readback that differs from the written entry sets the
// sticky error_o flag. When the macro is undefined, error_o is tied to 0.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               begin a sequence (ignored while busy_o)
//   base_index_i          first DCT index, sampled on an accepted start
//   dev_count_i           maximum number of devices, sampled on an accepted start
//   abort_i               engine terminated DAA; no further devices
//   byte_valid_i/_ready_o byte stream handshake
//   byte_i                PID[47:40]..PID[7:0], BCR, DCR
//   dyn_addr_i            dynamic address, sampled with the 8th byte
//   dct_write_valid_o     DCT write strobe
//   dct_read_valid_o      DCT request strobe / full-mask qualifier
//   dct_index_o           DCT entry index
//   dct_wdata_o           DCT entry data
//   dct_rdata_i           DCT read data, valid the cycle after a request
//   busy_o, done_o        sequence in progress / one-cycle end pulse
//   entries_o             entries written in the current/last sequence
//   error_o               sticky readback mismatch
module dct_daa_writer #(
    parameter int unsigned DctAw    = 7,
    parameter int unsigned DctDepth = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DctAw-1:0] base_index_i,
    input  logic [DctAw:0]   dev_count_i,
    input  logic             abort_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    input  logic [7:0]       byte_i,
    input  logic [6:0]       dyn_addr_i,
    output logic             dct_write_valid_o,
    output logic             dct_read_valid_o,
    output logic [DctAw-1:0] dct_index_o,
    output logic [127:0]     dct_wdata_o,
    input  logic [127:0]     dct_rdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DctAw:0]   entries_o,
    output logic             error_o
);

    localparam logic [DctAw-1:0] LastIdx = DctAw'(DctDepth - 1);
    localparam logic [DctAw:0]   CntOne  = (DctAw + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
`ifdef DCT_DAA_READBACK_EN
        StVerifyRd,
        StVerifyCmp,
`endif
        StDone
    } state_e;

    state_e           state_q;
    logic [DctAw-1:0] index_q;
    logic [DctAw:0]   remaining_q;
    logic [DctAw:0]   entries_q;
    logic [2:0]       byte_cnt_q;
    logic [47:0]      pid_q;
    logic [7:0]       bcr_q;
    logic [7:0]       dcr_q;
    logic [6:0]       dyn_q;
    logic             abort_pend_q;
    logic             wr_q;
    logic             rd_q;
    logic             done_q;
    logic             error_q;

    logic [DctAw-1:0] index_next;
    logic [127:0]     entry;

    assign index_next = (index_q == LastIdx) ? '0 : index_q + 1'b1;

    // The PID halves are swapped in the entry: PID[47:16] goes in the low word.
    assign entry = {25'd0, dyn_q, 16'd0, bcr_q, dcr_q, 16'd0, pid_q[15:0], pid_q[47:16]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            index_q      <= '0;
            remaining_q  <= '0;
            entries_q    <= '0;
            byte_cnt_q   <= '0;
            pid_q        <= '0;
            bcr_q        <= '0;
            dcr_q        <= '0;
            dyn_q        <= '0;
            abort_pend_q <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        entries_q    <= '0;
                        error_q      <= 1'b0;
                        abort_pend_q <= 1'b0;
                        byte_cnt_q   <= '0;
                        index_q      <= base_index_i;
                        remaining_q  <= dev_count_i;
                        if (dev_count_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (abort_i) begin
                        // The partial device is dropped; no write is issued.
                        byte_cnt_q <= '0;
                        state_q    <= StDone;
                        done_q     <= 1'b1;
                    end else if (byte_valid_i) begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        case (byte_cnt_q)
                            3'd6: bcr_q <= byte_i;
                            3'd7: begin
                                dcr_q   <= byte_i;
                                dyn_q   <= dyn_addr_i;
                                state_q <= StWrite;
                                wr_q    <= 1'b1;
                                rd_q    <= 1'b1;
                            end
                            // Six shifts fully replace the previous PID.
                            default: pid_q <= {pid_q[39:0], byte_i};
                        endcase
                    end
                end
                StWrite: begin
                    entries_q   <= entries_q + CntOne;
                    remaining_q <= remaining_q - CntOne;
                    if (abort_i) begin
                        abort_pend_q <= 1'b1;
                    end
`ifdef DCT_DAA_READBACK_EN
                    state_q <= StVerifyRd;
                    rd_q    <= 1'b1;
`else
                    if (remaining_q == CntOne || abort_i || abort_pend_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StCollect;
                        index_q <= index_next;
                    end
`endif
                end
`ifdef DCT_DAA_READBACK_EN
                StVerifyRd: begin
                    if (abort_i) begin
                        abort_pend_q <= 1'b1;
                    end
                    state_q <= StVerifyCmp;
                end
                StVerifyCmp: begin
                    if (dct_rdata_i != entry) begin
                        error_q <= 1'b1;
                    end
                    // remaining_q was already decremented in StWrite.
                    if (remaining_q == '0 || abort_i || abort_pend_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StCollect;
                        index_q <= index_next;
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o            = (state_q != StIdle);
    assign byte_ready_o      = (state_q == StCollect);
    assign dct_write_valid_o = wr_q;
    assign dct_read_valid_o  = rd_q;
    assign dct_index_o       = index_q;
    assign dct_wdata_o       = entry;
    assign done_o            = done_q;
    assign entries_o         = entries_q;

`ifdef DCT_DAA_READBACK_EN
    assign error_o = error_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^{dct_rdata_i, error_q};
    assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dct_daa_writer.sv
module tb_dct_daa_writer;

    localparam int unsigned DctAw    = 7;
    localparam int unsigned DctDepth = 128;
`ifdef DCT_DAA_READBACK_EN
    localparam int VerifyLat = 3;
    localparam bit Verify    = 1'b1;
`else
    localparam int VerifyLat = 1;
    localparam bit Verify    = 1'b0;
`endif
    localparam logic [127:0] Lit = 128'h0000_0009_0000_C0D1_0000_89AB_0123_4567;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [DctAw-1:0] base_index = '0;
    logic [DctAw:0]   dev_count = '0;
    logic             abort = 1'b0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic [7:0]       byte_in = '0;
    logic [6:0]       dyn_addr = '0;
    logic             wr_valid;
    logic             rd_valid;
    logic [DctAw-1:0] dct_index;
    logic [127:0]     wdata;
    logic [127:0]     rdata = '0;
    logic             busy;
    logic             done;
    logic [DctAw:0]   entries;
    logic             error;

    always #5 clk = ~clk;

    dct_daa_writer #(.DctAw(DctAw), .DctDepth(DctDepth)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .base_index_i      (base_index),
        .dev_count_i       (dev_count),
        .abort_i           (abort),
        .byte_valid_i      (byte_valid),
        .byte_ready_o      (byte_ready),
        .byte_i            (byte_in),
        .dyn_addr_i        (dyn_addr),
        .dct_write_valid_o (wr_valid),
        .dct_read_valid_o  (rd_valid),
        .dct_index_o       (dct_index),
        .dct_wdata_o       (wdata),
        .dct_rdata_i       (rdata),
        .busy_o            (busy),
        .done_o            (done),
        .entries_o         (entries),
        .error_o           (error)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Scoreboard of expected writes and observations of the current sequence
    logic [DctAw-1:0] exp_idx_q[$];
    logic [127:0]     exp_dat_q[$];
    logic [DctAw-1:0] seen_idx[$];
    logic [127:0]     last_wdata = '0;
    logic [DctAw-1:0] last_widx = '0;
    int               seq_wr_cnt = 0;
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               last_wr_cyc = 0;
    int               corrupt_wr = 0;
    logic [127:0]     mem [DctDepth];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [159:0] act,
                         input logic [159:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Entry layout built field by field from the table format.
    function automatic logic [127:0] model_entry(input logic [47:0] pid, input logic [7:0] bcr,
                                                 input logic [7:0] dcr, input logic [6:0] dyn);
        logic [127:0] e;
        e          = '0;
        e[31:0]    = pid[47:16];
        e[47:32]   = pid[15:0];
        e[71:64]   = dcr;
        e[79:72]   = bcr;
        e[102:96]  = dyn;
        return e;
    endfunction

    // DCT table model: stores writes, returns read data one cycle after a request.
    always @(posedge clk) begin
        if (wr_valid) mem[dct_index] <= wdata;
        if (rd_valid && !wr_valid) begin
            rdata <= mem[dct_index] ^ ((corrupt_wr != 0 && seq_wr_cnt == corrupt_wr) ?
                                       (128'd1 << 100) : 128'd0);
        end
    end

    // Per-cycle compare against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                seq_wr_cnt++;
                last_wr_cyc = cyc;
                seen_idx.push_back(dct_index);
                last_wdata = wdata;
                last_widx  = dct_index;
                check("write_has_mask", rd_valid == 1'b1, rd_valid, 1);
                check("write_expected", exp_idx_q.size() != 0, exp_idx_q.size(), 1);
                if (exp_idx_q.size() != 0) begin
                    logic [DctAw-1:0] ei;
                    logic [127:0]     ed;
                    ei = exp_idx_q.pop_front();
                    ed = exp_dat_q.pop_front();
                    check("write_index", dct_index == ei, dct_index, ei);
                    check("write_data", wdata == ed, wdata, ed);
                end
            end else if (rd_valid) begin
                check("readonly_only_with_verify", Verify, 0, 1);
                check("verify_index", dct_index == last_widx, dct_index, last_widx);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_seq(input logic [DctAw-1:0] base, input int count, input bit throttle,
                           input int abort_at, input int corrupt, input bit fixed_first);
        logic [7:0] b [8];
        logic [6:0] dyn;
        int accepted, start_cyc, abort_cyc, done0, nexp, budget;
        bit stop, first, exp_err;
        accepted  = 0;
        abort_cyc = -1;
        nexp      = 0;
        budget    = 600;
        stop      = 1'b0;
        first     = 1'b1;
        seen_idx.delete();
        seq_wr_cnt = 0;
        corrupt_wr = corrupt;
        done0      = done_cnt;

        @(posedge clk); #1;
        start      = 1'b1;
        base_index = base;
        dev_count  = (DctAw + 1)'(count);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("error_cleared_on_start", error == 1'b0, error, 0);
        if (count > 0) check("ready_after_start", byte_ready == 1'b1, byte_ready, 1);
        @(posedge clk); #1;

        for (int d = 0; d < count && !stop; d++) begin
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
            dyn = 7'($urandom);
            if (fixed_first && d == 0) begin
                b   = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hC0, 8'hD1};
                dyn = 7'h09;
            end
            for (int i = 0; i < 8 && !stop; ) begin
                budget--;
                if (budget == 0) begin
                    check("byte_budget", 1'b0, accepted, count * 8);
                    stop = 1'b1;
                end else if (abort_at >= 0 && accepted == abort_at) begin
                    byte_valid = 1'b0;
                    abort      = 1'b1;
                    @(negedge clk);
                    abort_cyc = cyc;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    stop  = 1'b1;
                end else begin
                    byte_valid = !throttle || ($urandom_range(0, 1) == 1);
                    byte_in    = byte_valid ? b[i] : 8'($urandom);
                    dyn_addr   = dyn;
                    @(negedge clk);
                    if (byte_valid && byte_ready) begin
                        accepted++;
                        i++;
                        if (i == 8) begin
                            exp_idx_q.push_back(DctAw'((int'(base) + d) % int'(DctDepth)));
                            exp_dat_q.push_back(model_entry({b[0], b[1], b[2], b[3], b[4], b[5]},
                                                            b[6], b[7], dyn));
                            nexp++;
                        end
                    end
                    @(posedge clk); #1;
                end
            end
        end
        byte_valid = 1'b0;

        for (int t = 0; t < 100 && done_cnt == done0; t++) @(negedge clk);
        check("done_seen", done_cnt != done0, done_cnt - done0, 1);
        check("entries", entries == (DctAw + 1)'(nexp), entries, nexp);
        check("all_writes_seen", exp_idx_q.size() == 0, exp_idx_q.size(), 0);
        check("write_count", seq_wr_cnt == nexp, seq_wr_cnt, nexp);
        if (abort_cyc >= 0 && abort_at % 8 != 0)
            check("done_after_abort", done_cyc - abort_cyc == 1, done_cyc - abort_cyc, 1);
        else if (nexp > 0)
            check("done_after_last_write", done_cyc - last_wr_cyc == VerifyLat,
                  done_cyc - last_wr_cyc, VerifyLat);
        else
            check("done_zero_count", (done_cyc - start_cyc) inside {[1:2]},
                  done_cyc - start_cyc, 2);
        exp_err = Verify && corrupt > 0 && corrupt <= nexp;
        check("error_flag", error == exp_err, error, exp_err);
        exp_idx_q.delete();
        exp_dat_q.delete();
        @(negedge clk);
        check("idle_after_done", busy == 1'b0 && done == 1'b0, {busy, done}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {byte_ready, wr_valid, rd_valid, dct_index, wdata, busy, done,
                                entries, error} == '0, busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        check("model_pin", model_entry(48'h0123456789AB, 8'hC0, 8'hD1, 7'h09) == Lit,
              model_entry(48'h0123456789AB, 8'hC0, 8'hD1, 7'h09), Lit);

        // Single device
        run_seq(7'd5, 1, 1'b0, -1, 0, 1'b1);
        check("single_index", seen_idx.size() == 1 && seen_idx[0] == 7'd5, seen_idx.size(), 1);
        check("single_wdata", last_wdata == Lit, last_wdata, Lit);
        check("single_entries", entries == 8'd1, entries, 1);

        // Same device under 50% valid throttling
        run_seq(7'd5, 1, 1'b1, -1, 0, 1'b1);
        check("throttle_wdata", last_wdata == Lit, last_wdata, Lit);

        // Index wrap
        run_seq(7'd127, 2, 1'b0, -1, 0, 1'b0);
        check("wrap_count", seen_idx.size() == 2, seen_idx.size(), 2);
        if (seen_idx.size() == 2) begin
            check("wrap_first", seen_idx[0] == 7'd127, seen_idx[0], 127);
            check("wrap_second", seen_idx[1] == 7'd0, seen_idx[1], 0);
        end
        check("wrap_entries", entries == 8'd2, entries, 2);

        // Abort after one device plus three bytes
        run_seq(7'd10, 3, 1'b0, 11, 0, 1'b0);
        check("abort_writes", seq_wr_cnt == 1, seq_wr_cnt, 1);
        check("abort_entries", entries == 8'd1, entries, 1);

        // Zero count
        run_seq(7'd20, 0, 1'b0, -1, 0, 1'b0);
        check("zero_writes", seq_wr_cnt == 0, seq_wr_cnt, 0);

`ifdef DCT_DAA_READBACK_EN
        // Readback mismatch on the second of three devices
        run_seq(7'd30, 3, 1'b0, -1, 2, 1'b0);
        check("rb_error_set", error == 1'b1, error, 1);
        check("rb_all_writes", seq_wr_cnt == 3, seq_wr_cnt, 3);
        run_seq(7'd40, 1, 1'b0, -1, 0, 1'b0);
        check("rb_error_clear", error == 1'b0, error, 0);
`endif

        // Randomised sequences
        for (int k = 0; k < 10; k++) begin
            int cnt, ab, cor;
            cnt = $urandom_range(1, 4);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cnt * 8 - 1) : -1;
            cor = Verify ? $urandom_range(0, cnt) : 0;
            run_seq(7'($urandom), cnt, 1'($urandom), ab, cor, 1'b0);
        end

        // Reset in the middle of COLLECT
        seq_wr_cnt = 0;
        corrupt_wr = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        base_index = 7'd50;
        dev_count  = 8'd2;
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b1;
        repeat (3) begin
            byte_in = 8'($urandom);
            @(posedge clk); #1;
        end
        rst        = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {byte_ready, wr_valid, rd_valid, dct_index, wdata, busy, done,
                                   entries, error} == '0, busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset_no_write", seq_wr_cnt == 0, seq_wr_cnt, 0);
        check("midreset_idle", busy == 1'b0, busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
